mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-cycle memory port between a CPU and a DMA requester.
// Each transfer spends one cycle in IDLE for arbitration, one in XFER on the bus, and one in ACK.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_gnt,
    output logic              dma_gnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              ownerDma_q, ownerDma_d;
    logic              lastDma_q, lastDma_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpuRdata_q, cpuRdata_d;
    logic [DATA_W-1:0] dmaRdata_q, dmaRdata_d;
    logic              pickDma;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        state_d    = state_q;
        ownerDma_d = ownerDma_q;
        lastDma_d  = lastDma_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cpuRdata_d = cpuRdata_q;
        dmaRdata_d = dmaRdata_q;
        pickDma    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    pickDma    = (cpu_req && dma_req) ? ~lastDma_q : dma_req;
                    ownerDma_d = pickDma;
                    lastDma_d  = pickDma;
                    we_d       = pickDma ? dma_we    : cpu_we;
                    addr_d     = pickDma ? dma_addr  : cpu_addr;
                    wdata_d    = pickDma ? dma_wdata : cpu_wdata;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (!we_q) begin
                    if (ownerDma_q) begin
                        dmaRdata_d = mem_rdata;
                    end else begin
                        cpuRdata_d = mem_rdata;
                    end
                end
                state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ownerDma_q <= 1'b0;
            lastDma_q  <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpuRdata_q <= '0;
            dmaRdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ownerDma_q <= ownerDma_d;
            lastDma_q  <= lastDma_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpuRdata_q <= cpuRdata_d;
            dmaRdata_q <= dmaRdata_d;
        end
    end

    // Bus and handshake outputs decode straight from state so a reset drops them at once.
    always_comb begin
        mem_we    = (state_q == XFER) && we_q;
        mem_addr  = (state_q == XFER) ? addr_q  : '0;
        mem_wdata = (state_q == XFER) ? wdata_q : '0;
        cpu_gnt   = (state_q == XFER) && !ownerDma_q;
        dma_gnt   = (state_q == XFER) && ownerDma_q;
        cpu_ack   = (state_q == ACK)  && !ownerDma_q;
        dma_ack   = (state_q == ACK)  && ownerDma_q;
        cpu_stall = cpu_req && !cpu_ack;
        cpu_rdata = cpuRdata_q;
        dma_rdata = dmaRdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transfer-level model is compared every cycle,
// and directed scenarios pin the model with hand-computed expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic        cpu_ack, dma_ack, cpu_stall, cpu_gnt, dma_gnt, mem_we;
    logic [7:0]  cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    logic [7:0]  memArr [0:65535];

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt)
    );

    always #5 clk = ~clk;

    // Combinational memory; writes land on the rising edge when the DUT strobes mem_we.
    assign mem_rdata = memArr[mem_addr];
    always @(posedge clk) begin
        if (mem_we) memArr[mem_addr] = mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: slot counts the cycles the granted transfer still owns
    // (2 = on the memory bus, 1 = acknowledge cycle, 0 = arbiter free).
    int          slot = 0;
    bit          lastWasDma = 1'b1;
    bit          curDma = 1'b0;
    bit          curWe = 1'b0;
    logic [15:0] curAddr = '0;
    logic [7:0]  curWdata = '0;
    logic [7:0]  expCpuRdata = '0;
    logic [7:0]  expDmaRdata = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            slot        = 0;
            lastWasDma  = 1'b1;
            expCpuRdata = '0;
            expDmaRdata = '0;
        end else if (slot == 0) begin
            if (cpu_req || dma_req) begin
                curDma     = (cpu_req && dma_req) ? !lastWasDma : dma_req;
                lastWasDma = curDma;
                curWe      = curDma ? dma_we    : cpu_we;
                curAddr    = curDma ? dma_addr  : cpu_addr;
                curWdata   = curDma ? dma_wdata : cpu_wdata;
                slot       = 2;
            end
        end else if (slot == 2) begin
            if (!curWe) begin
                if (curDma) expDmaRdata = memArr[curAddr];
                else        expCpuRdata = memArr[curAddr];
            end
            slot = 1;
        end else begin
            slot = 0;
        end
    end

    always @(negedge clk) begin
        checkOutput("cmp_cpu_gnt",   32'(cpu_gnt),   32'(slot == 2 && !curDma));
        checkOutput("cmp_dma_gnt",   32'(dma_gnt),   32'(slot == 2 && curDma));
        checkOutput("cmp_cpu_ack",   32'(cpu_ack),   32'(slot == 1 && !curDma));
        checkOutput("cmp_dma_ack",   32'(dma_ack),   32'(slot == 1 && curDma));
        checkOutput("cmp_mem_we",    32'(mem_we),    32'(slot == 2 && curWe));
        checkOutput("cmp_mem_addr",  32'(mem_addr),  32'((slot == 2) ? curAddr : 16'h0));
        checkOutput("cmp_mem_wdata", 32'(mem_wdata), 32'((slot == 2) ? curWdata : 8'h0));
        checkOutput("cmp_cpu_rdata", 32'(cpu_rdata), 32'(expCpuRdata));
        checkOutput("cmp_dma_rdata", 32'(dma_rdata), 32'(expDmaRdata));
        checkOutput("cmp_cpu_stall", 32'(cpu_stall), 32'(cpu_req && !(slot == 1 && !curDma)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit creq, input bit cwe, input logic [15:0] caddr,
                                 input logic [7:0] cwd, input bit dreq, input bit dwe,
                                 input logic [15:0] daddr, input logic [7:0] dwd);
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) memArr[i] = 8'(i) ^ 8'h5A;
        memArr[16'h0012] = 8'hA5;

        repeat (2) tick();
        reset = 1'b0;
        checkOutput("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        checkOutput("rst_dma_rdata", 32'(dma_rdata), 32'h0);
        checkOutput("rst_mem_we",    32'(mem_we),    32'h0);

        // Idle bus for ten cycles.
        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput("idle_mem_we",   32'(mem_we),             32'h0);
            checkOutput("idle_gnt",      32'({cpu_gnt, dma_gnt}), 32'h0);
            checkOutput("idle_ack",      32'({cpu_ack, dma_ack}), 32'h0);
            checkOutput("idle_mem_addr", 32'(mem_addr),           32'h0);
        end

        // CPU read of 0x0012.
        applyStimulus(1'b1, 1'b0, 16'h0012, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
        #1;
        checkOutput("rd_k_stall", 32'(cpu_stall), 32'h1);
        checkOutput("rd_k_gnt",   32'(cpu_gnt),   32'h0);
        tick();
        checkOutput("rd_k1_gnt",   32'(cpu_gnt),   32'h1);
        checkOutput("rd_k1_addr",  32'(mem_addr),  32'h0012);
        checkOutput("rd_k1_we",    32'(mem_we),    32'h0);
        checkOutput("rd_k1_stall", 32'(cpu_stall), 32'h1);
        tick();
        checkOutput("rd_k2_ack",   32'(cpu_ack),   32'h1);
        checkOutput("rd_k2_rdata", 32'(cpu_rdata), 32'hA5);
        checkOutput("rd_k2_stall", 32'(cpu_stall), 32'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        checkOutput("rd_k3_ack", 32'(cpu_ack), 32'h0);

        // DMA write of 0x3C to 0x0100.
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0100, 8'h3C);
        tick();
        checkOutput("wr_k1_we",    32'(mem_we),    32'h1);
        checkOutput("wr_k1_addr",  32'(mem_addr),  32'h0100);
        checkOutput("wr_k1_wdata", 32'(mem_wdata), 32'h3C);
        checkOutput("wr_k1_gnt",   32'(dma_gnt),   32'h1);
        tick();
        checkOutput("wr_k2_we",    32'(mem_we),    32'h0);
        checkOutput("wr_k2_ack",   32'(dma_ack),   32'h1);
        checkOutput("wr_k2_cpurd", 32'(cpu_rdata), 32'hA5);
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        checkOutput("wr_mem_0100", 32'(memArr[16'h0100]), 32'h3C);

        // DMA reads back what it wrote.
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0100, 8'h0);
        repeat (2) tick();
        checkOutput("dmard_ack",   32'(dma_ack),   32'h1);
        checkOutput("dmard_rdata", 32'(dma_rdata), 32'h3C);
        checkOutput("dmard_cpurd", 32'(cpu_rdata), 32'hA5);
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();

        // Both requesters held after reset: grants alternate CPU, DMA, CPU.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h0012, 8'h0, 1'b1, 1'b0, 16'h0100, 8'h0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            checkOutput($sformatf("rr_k%0d_cpu_gnt", c), 32'(cpu_gnt), 32'(c == 1 || c == 7));
            checkOutput($sformatf("rr_k%0d_dma_gnt", c), 32'(dma_gnt), 32'(c == 4));
            checkOutput($sformatf("rr_k%0d_cpu_ack", c), 32'(cpu_ack), 32'(c == 2 || c == 8));
            checkOutput($sformatf("rr_k%0d_dma_ack", c), 32'(dma_ack), 32'(c == 5));
        end
        checkOutput("rr_cpu_rdata", 32'(cpu_rdata), 32'hA5);
        checkOutput("rr_dma_rdata", 32'(dma_rdata), 32'h3C);
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();

        // Reset during the memory cycle of a CPU write aborts it.
        applyStimulus(1'b1, 1'b1, 16'h0200, 8'h77, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        checkOutput("abort_we_before", 32'(mem_we), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("abort_we_after",  32'(mem_we),   32'h0);
        checkOutput("abort_gnt_after", 32'(cpu_gnt),  32'h0);
        checkOutput("abort_addr",      32'(mem_addr), 32'h0);
        cpu_req = 1'b0;
        tick();
        checkOutput("abort_no_ack", 32'(cpu_ack), 32'h0);
        reset = 1'b0;
        tick();
        checkOutput("abort_no_ack2", 32'(cpu_ack), 32'h0);
        checkOutput("abort_mem",     32'(memArr[16'h0200]), 32'h5A);
        applyStimulus(1'b1, 1'b0, 16'h0012, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        checkOutput("post_gnt", 32'(cpu_gnt), 32'h1);
        tick();
        checkOutput("post_ack",   32'(cpu_ack),   32'h1);
        checkOutput("post_rdata", 32'(cpu_rdata), 32'hA5);
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
